// File: rtl/ex_stage_if.sv
// ID -> EX -> MEM bus of the execute stage: operand bundle in, EX/MEM bundle,
// branch pulse and hazard-unit signals out; forwarding inputs sit here too.
interface ex_stage_if #(
    parameter int INSTR_ADDR_W = 8
);
    // Plain pipeline bus: no valid/ready. The stage accepts pipeline_re_i on every
    // posedge unless stall_i (hold) or flush_i (bubble) is asserted.
    logic [57+INSTR_ADDR_W:0] pipeline_re_i;
    logic                     stall_i;
    logic                     flush_i;
    logic [2:0]               src1_addr;
    logic [2:0]               src2_addr;
    logic                     wb_fwd_en;
    logic [2:0]               wb_fwd_dest;
    logic [15:0]              wb_fwd_data;
    logic [37:0]              pipeline_ou;
    logic                     branch_taken_o;
    logic [INSTR_ADDR_W-1:0]  branch_target_o;
    logic [2:0]               ex_op_dest;

    modport slave (
        input  pipeline_re_i, stall_i, flush_i, src1_addr, src2_addr,
               wb_fwd_en, wb_fwd_dest, wb_fwd_data,
        output pipeline_ou, branch_taken_o, branch_target_o, ex_op_dest
    );

    modport master (
        output pipeline_re_i, stall_i, flush_i, src1_addr, src2_addr,
               wb_fwd_en, wb_fwd_dest, wb_fwd_data,
        input  pipeline_ou, branch_taken_o, branch_target_o, ex_op_dest
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: 16-bit ALU, BZ branch resolution and the EX/MEM register.
// Optional operand forwarding is compiled in with `define EX_FORWARD_EN.
module ex_stage #(
    parameter int INSTR_ADDR_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    ex_stage_if.slave  bus
);
    localparam int TGT_LSB = 57;

    logic                    branch_en;
    logic [INSTR_ADDR_W-1:0] branch_tgt;
    logic [2:0]              alu_cmd;
    logic [15:0]             id_src1;
    logic [15:0]             id_src2;
    logic                    mem_we;
    logic [15:0]             id_mem_wd;
    logic [4:0]              wb_bits;

    assign branch_en  = bus.pipeline_re_i[TGT_LSB+INSTR_ADDR_W];
    assign branch_tgt = bus.pipeline_re_i[TGT_LSB +: INSTR_ADDR_W];
    assign alu_cmd    = bus.pipeline_re_i[56:54];
    assign id_src1    = bus.pipeline_re_i[53:38];
    assign id_src2    = bus.pipeline_re_i[37:22];
    assign mem_we     = bus.pipeline_re_i[21];
    assign id_mem_wd  = bus.pipeline_re_i[20:5];
    assign wb_bits    = bus.pipeline_re_i[4:0];

    logic [37:0]             pou_q, pou_d;
    logic                    taken_q;
    logic [INSTR_ADDR_W-1:0] target_q;

    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] mem_wd;

`ifdef EX_FORWARD_EN
    logic exm_fwd_ok;
    logic a_exm_hit, a_wb_hit, b_exm_hit, b_wb_hit;

    // Only a pending ALU write-back can be forwarded from EX/MEM; loads are not ready yet.
    assign exm_fwd_ok = pou_q[4] && !pou_q[0];
    assign a_exm_hit  = exm_fwd_ok && (pou_q[3:1] == bus.src1_addr);
    assign b_exm_hit  = exm_fwd_ok && (pou_q[3:1] == bus.src2_addr);
    assign a_wb_hit   = bus.wb_fwd_en && (bus.wb_fwd_dest == bus.src1_addr);
    assign b_wb_hit   = bus.wb_fwd_en && (bus.wb_fwd_dest == bus.src2_addr);

    always_comb begin
        op_a = id_src1;
        op_b = id_src2;
        if (a_exm_hit)     op_a = pou_q[37:22];
        else if (a_wb_hit) op_a = bus.wb_fwd_data;
        if (b_exm_hit)     op_b = pou_q[37:22];
        else if (b_wb_hit) op_b = bus.wb_fwd_data;
    end

    assign mem_wd = (mem_we && (b_exm_hit || b_wb_hit)) ? op_b : id_mem_wd;
`else
    assign op_a   = id_src1;
    assign op_b   = id_src2;
    assign mem_wd = id_mem_wd;
`endif

    logic [15:0] alu_res;
    logic [3:0]  shamt;

    assign shamt = op_b[3:0];

    always_comb begin
        alu_res = 16'h0000;
        case (alu_cmd)
            3'b000:  alu_res = op_a + op_b;
            3'b001:  alu_res = op_a - op_b;
            3'b010:  alu_res = op_a & op_b;
            3'b011:  alu_res = op_a | op_b;
            3'b100:  alu_res = op_a ^ op_b;
            3'b101:  alu_res = op_a << shamt;
            3'b110:  alu_res = $unsigned($signed(op_a) >>> shamt);
            default: alu_res = op_a >> shamt;
        endcase
    end

    logic take_branch;

    assign take_branch = branch_en && (op_a == 16'h0000);
    assign pou_d       = {alu_res, mem_we, mem_wd, wb_bits};

    // Stall holds the bundle and target but always drops the pulse so it fires once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pou_q    <= '0;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else if (bus.flush_i) begin
            pou_q   <= '0;
            taken_q <= 1'b0;
        end else if (bus.stall_i) begin
            taken_q <= 1'b0;
        end else begin
            pou_q   <= pou_d;
            taken_q <= take_branch;
            if (take_branch) target_q <= branch_tgt;
        end
    end

    assign bus.pipeline_ou     = pou_q;
    assign bus.branch_taken_o  = taken_q;
    assign bus.branch_target_o = target_q;
    assign bus.ex_op_dest      = bus.pipeline_re_i[3:1];
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU sweep, store pass-through, BZ pulse,
// stall/flush, asynchronous reset and (when compiled in) forwarding.
module tb_ex_stage;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    ex_stage_if #(.INSTR_ADDR_W(8)) bus ();

    ex_stage #(.INSTR_ADDR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [65:0] pack(input logic br, input logic [7:0] tgt,
                                         input logic [2:0] cmd, input logic [15:0] a,
                                         input logic [15:0] b, input logic mwe,
                                         input logic [15:0] mwd, input logic [4:0] wb);
        return {br, tgt, cmd, a, b, mwe, mwd, wb};
    endfunction

    task automatic check(input string tag, input logic [37:0] obs, input logic [37:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [65:0] v);
        bus.pipeline_re_i = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input string tag, input logic [2:0] cmd, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp);
        drive(pack(1'b0, 8'h00, cmd, a, b, 1'b0, 16'h0000, 5'b0));
        step();
        check(tag, {22'h0, bus.pipeline_ou[37:22]}, {22'h0, exp});
    endtask

    initial begin
        n_checks          = 0;
        n_pass            = 0;
        rst_n             = 1'b0;
        bus.stall_i       = 1'b0;
        bus.flush_i       = 1'b0;
        bus.src1_addr     = 3'd0;
        bus.src2_addr     = 3'd0;
        bus.wb_fwd_en     = 1'b0;
        bus.wb_fwd_dest   = 3'd0;
        bus.wb_fwd_data   = 16'h0;
        drive(pack(1'b0, 8'h00, 3'b000, 16'h1, 16'h1, 1'b0, 16'h0, 5'b1_101_0));

        step();
        check("reset_pou", bus.pipeline_ou, 38'h0);
        check("reset_taken", {37'h0, bus.branch_taken_o}, 38'h0);
        check("reset_target", {30'h0, bus.branch_target_o}, 38'h0);
        check("ex_op_dest", {35'h0, bus.ex_op_dest}, 38'd5);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_idle", bus.pipeline_ou, 38'h0);

        alu_op("add_wrap", 3'b000, 16'hFFFF, 16'h0002, 16'h0001);
        alu_op("sub_wrap", 3'b001, 16'h0000, 16'h0001, 16'hFFFF);
        alu_op("and",      3'b010, 16'hF0F0, 16'hFF00, 16'hF000);
        alu_op("or",       3'b011, 16'hF0F0, 16'h0F0F, 16'hFFFF);
        alu_op("xor",      3'b100, 16'hAAAA, 16'hFFFF, 16'h5555);
        alu_op("sl15",     3'b101, 16'h0001, 16'h000F, 16'h8000);
        alu_op("sr_arith", 3'b110, 16'h8000, 16'h0013, 16'hF000);
        alu_op("sru",      3'b111, 16'h8000, 16'h0003, 16'h1000);

        // store pass-through with write-back bits 1_010_0
        drive(pack(1'b0, 8'h00, 3'b000, 16'h0010, 16'h0004, 1'b1, 16'hBEEF, 5'b1_010_0));
        step();
        check("store_bundle", bus.pipeline_ou, {16'h0014, 1'b1, 16'hBEEF, 5'b1_010_0});

        drive(pack(1'b1, 8'h3C, 3'b000, 16'h0000, 16'h0000, 1'b0, 16'h0, 5'b0));
        step();
        check("bz_taken", {37'h0, bus.branch_taken_o}, 38'd1);
        check("bz_target", {30'h0, bus.branch_target_o}, 38'h3C);
        drive(pack(1'b0, 8'h11, 3'b000, 16'h0000, 16'h0000, 1'b0, 16'h0, 5'b0));
        step();
        check("bz_one_cycle", {37'h0, bus.branch_taken_o}, 38'd0);
        check("bz_target_keep", {30'h0, bus.branch_target_o}, 38'h3C);

        drive(pack(1'b1, 8'h55, 3'b000, 16'h0001, 16'h0000, 1'b0, 16'h0, 5'b0));
        step();
        check("bz_not_taken", {37'h0, bus.branch_taken_o}, 38'd0);
        check("bz_nt_target", {30'h0, bus.branch_target_o}, 38'h3C);

        drive(pack(1'b0, 8'h00, 3'b000, 16'h0001, 16'h0001, 1'b1, 16'h1234, 5'b1_110_0));
        step();
        check("pre_stall", bus.pipeline_ou, {16'h0002, 1'b1, 16'h1234, 5'b1_110_0});
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(pack(1'b0, 8'h00, 3'b100, 16'(i + 7), 16'h00F0, 1'b0, 16'(i), 5'(i)));
            step();
            check($sformatf("stall_hold%0d", i), bus.pipeline_ou,
                  {16'h0002, 1'b1, 16'h1234, 5'b1_110_0});
        end
        bus.stall_i = 1'b0;

        drive(pack(1'b1, 8'h77, 3'b000, 16'h0000, 16'h0009, 1'b0, 16'h0, 5'b0));
        step();
        check("bz2_taken", {37'h0, bus.branch_taken_o}, 38'd1);
        bus.stall_i = 1'b1;
        step();
        check("bz2_stall_no_repeat", {37'h0, bus.branch_taken_o}, 38'd0);
        check("bz2_stall_target", {30'h0, bus.branch_target_o}, 38'h77);
        check("bz2_stall_pou", {22'h0, bus.pipeline_ou[37:22]}, 38'h9);
        bus.flush_i = 1'b1;
        step();
        check("stall_flush_pou", bus.pipeline_ou, 38'h0);
        check("flush_target_keep", {30'h0, bus.branch_target_o}, 38'h77);
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;

        drive(pack(1'b1, 8'h42, 3'b000, 16'h0000, 16'h0005, 1'b0, 16'h0, 5'b1_001_0));
        step();
        check("pre_rst_pou", bus.pipeline_ou, {16'h0005, 1'b0, 16'h0, 5'b1_001_0});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pou", bus.pipeline_ou, 38'h0);
        check("async_rst_taken", {37'h0, bus.branch_taken_o}, 38'd0);
        check("async_rst_target", {30'h0, bus.branch_target_o}, 38'h0);
        @(negedge clk);
        rst_n = 1'b1;
        alu_op("first_after_rst", 3'b000, 16'h0002, 16'h0002, 16'h0004);

`ifdef EX_FORWARD_EN
        drive(pack(1'b0, 8'h00, 3'b000, 16'h0004, 16'h0001, 1'b0, 16'h0, 5'b1_011_0));
        bus.src1_addr = 3'd1;
        bus.src2_addr = 3'd2;
        step();
        check("fwd_prod", {22'h0, bus.pipeline_ou[37:22]}, 38'h5);
        drive(pack(1'b0, 8'h00, 3'b000, 16'h0000, 16'h0001, 1'b0, 16'h0, 5'b1_011_0));
        bus.src1_addr = 3'd3;
        bus.src2_addr = 3'd7;
        step();
        check("fwd_exmem", {22'h0, bus.pipeline_ou[37:22]}, 38'h6);
        bus.wb_fwd_en   = 1'b1;
        bus.wb_fwd_dest = 3'd3;
        bus.wb_fwd_data = 16'h0099;
        step();
        check("fwd_exmem_wins", {22'h0, bus.pipeline_ou[37:22]}, 38'h7);
`else
        drive(pack(1'b0, 8'h00, 3'b000, 16'h0004, 16'h0001, 1'b0, 16'h0, 5'b1_011_0));
        step();
        drive(pack(1'b0, 8'h00, 3'b000, 16'h0000, 16'h0001, 1'b0, 16'h0, 5'b1_011_0));
        bus.src1_addr   = 3'd3;
        bus.wb_fwd_en   = 1'b1;
        bus.wb_fwd_dest = 3'd3;
        bus.wb_fwd_data = 16'h0099;
        step();
        check("no_fwd_id_value", {22'h0, bus.pipeline_ou[37:22]}, 38'h1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
